dff_delay_line: RTL and testbench

- Parametrised successor to the single-stage 8-bit DFF: a WIDTH-bit register chain of DEPTH stages with per-stage valid, global enable (stall), synchronous flush and run-time selectable tap (0..DEPTH cycles of delay).
- Adds a built-in 3-word sequence detector on the selected output stream, with a saturating hit counter.
- Sits between a data source and downstream logic as a delay/alignment element; the detector gives benches and firmware an in-band pattern check.

---
 rtl/dff_delay_line_pkg.sv | 14 +
 rtl/dff_delay_line_seq3_detect.sv | 78 +++++++
 rtl/dff_delay_line.sv | 89 ++++++++
 tb/tb_dff_delay_line.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_delay_line_pkg.sv
// Shared types and default sizing for the delay line and its sequence detector.
package dff_delay_line_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        GOT1,
        GOT2
    } seq_state_e;

endpackage

// File: rtl/dff_delay_line_seq3_detect.sv
// Three-word in-order sequence detector with overlap handling, a registered hit
// pulse and a saturating hit counter.
module seq3_detect
    import dff_delay_line_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             sample_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic [WIDTH-1:0] pat0_i,
    input  logic [WIDTH-1:0] pat1_i,
    input  logic [WIDTH-1:0] pat2_i,
    output logic             seq_hit_o,
    output logic [CNT_W-1:0] hit_cnt_o
);

    seq_state_e       state_q, state_d;
    logic             hit_d;
    logic             seq_hit_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // On a miss in GOT2 the word may still extend a shorter prefix of the pattern.
    always_comb begin
        state_d = state_q;
        hit_d   = 1'b0;
        cnt_d   = cnt_q;
        if (flush_i) begin
            state_d = IDLE;
        end else if (sample_i) begin
            case (state_q)
                IDLE: begin
                    state_d = (word_i == pat0_i) ? GOT1 : IDLE;
                end
                GOT1: begin
                    if (word_i == pat1_i)      state_d = GOT2;
                    else if (word_i == pat0_i) state_d = GOT1;
                    else                       state_d = IDLE;
                end
                GOT2: begin
                    if (word_i == pat2_i) begin
                        hit_d = 1'b1;
                        if (pat0_i == pat1_i && pat1_i == pat2_i) state_d = GOT2;
                        else if (pat2_i == pat0_i)                state_d = GOT1;
                        else                                      state_d = IDLE;
                    end else if (pat0_i == pat1_i && word_i == pat1_i) begin
                        state_d = GOT2;
                    end else if (word_i == pat0_i) begin
                        state_d = GOT1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (hit_d && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            seq_hit_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            seq_hit_q <= hit_d;
            cnt_q     <= cnt_d;
        end
    end

    assign seq_hit_o = seq_hit_q;
    assign hit_cnt_o = cnt_q;

endmodule

// File: rtl/dff_delay_line.sv
// WIDTH x DEPTH register delay line with per-stage valid, stall, flush and a
// run-time tap select, feeding a three-word sequence detector.
module dff_delay_line
    import dff_delay_line_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int SEL_W = $clog2(DEPTH + 1),
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             din_vld,
    input  logic [WIDTH-1:0] din,
    input  logic [SEL_W-1:0] delay_sel,
    input  logic [WIDTH-1:0] pat0,
    input  logic [WIDTH-1:0] pat1,
    input  logic [WIDTH-1:0] pat2,
    output logic             dout_vld,
    output logic [WIDTH-1:0] dout,
    output logic             seq_hit,
    output logic [CNT_W-1:0] hit_cnt
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [WIDTH-1:0] tap_data;
    logic             tap_vld;
    logic             sample;

    // Invalid words shift exactly like valid ones so timing never depends on data.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign stage_d[i] = flush ? '0   : (en ? din     : stage_q[i]);
            assign vld_d[i]   = flush ? 1'b0 : (en ? din_vld : vld_q[i]);
        end else begin : g_body
            assign stage_d[i] = flush ? '0   : (en ? stage_q[i-1] : stage_q[i]);
            assign vld_d[i]   = flush ? 1'b0 : (en ? vld_q[i-1]   : vld_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
            vld_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
            vld_q <= vld_d;
        end
    end

    // Selects above DEPTH clamp to the last stage.
    always_comb begin
        tap_data = din;
        tap_vld  = din_vld;
        for (int k = 1; k <= DEPTH; k++) begin
            if (int'(delay_sel) == k || (k == DEPTH && int'(delay_sel) > DEPTH)) begin
                tap_data = stage_q[k-1];
                tap_vld  = vld_q[k-1];
            end
        end
    end

    // Reset also silences the bypass path so nothing leaks downstream.
    assign dout     = rst ? tap_data : '0;
    assign dout_vld = rst & tap_vld;
    assign sample   = en & ~flush & tap_vld;

    seq3_detect #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_detect (
        .clk       (clk),
        .rst_n     (rst),
        .flush_i   (flush),
        .sample_i  (sample),
        .word_i    (tap_data),
        .pat0_i    (pat0),
        .pat1_i    (pat1),
        .pat2_i    (pat2),
        .seq_hit_o (seq_hit),
        .hit_cnt_o (hit_cnt)
    );

endmodule

// File: tb/tb_dff_delay_line.sv
// Scoreboard bench for dff_delay_line: stimulus queues expected words and hits,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_dff_delay_line;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       flush;
    logic       din_vld;
    logic [7:0] din;
    logic [2:0] delay_sel;
    logic [7:0] pat0, pat1, pat2;

    logic        dout_vld;
    logic [7:0]  dout;
    logic        seq_hit;
    logic [15:0] hit_cnt;

    logic        dout_vld2;
    logic [7:0]  dout2;
    logic        seq_hit2;
    logic [1:0]  hit_cnt2;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } word_t;

    typedef struct {
        int          cyc;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } hit_t;

    word_t wordQ[$];
    hit_t  hitQ[$];
    word_t monW;
    hit_t  monH;

    int cyc       = 0;
    int nChecks   = 0;
    int nFails    = 0;
    int modelCnt  = 0;
    int modelCnt2 = 0;
    int baseCyc;

    dff_delay_line dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .din_vld   (din_vld),
        .din       (din),
        .delay_sel (delay_sel),
        .pat0      (pat0),
        .pat1      (pat1),
        .pat2      (pat2),
        .dout_vld  (dout_vld),
        .dout      (dout),
        .seq_hit   (seq_hit),
        .hit_cnt   (hit_cnt)
    );

    dff_delay_line #(.CNT_W(2)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .din_vld   (din_vld),
        .din       (din),
        .delay_sel (delay_sel),
        .pat0      (pat0),
        .pat1      (pat1),
        .pat2      (pat2),
        .dout_vld  (dout_vld2),
        .dout      (dout2),
        .seq_hit   (seq_hit2),
        .hit_cnt   (hit_cnt2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: every valid word and every hit pulse must match the head of its queue.
    always @(negedge clk) begin
        if (dout_vld) begin
            if (wordQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL unexpected_word: got 0x%0h, expected no valid word (cycle %0d)", dout, cyc);
            end else begin
                monW = wordQ.pop_front();
                checkOutput("dout", 32'(dout), 32'(monW.data));
                checkOutput("dout_cycle", cyc, monW.cyc);
            end
        end
        if (seq_hit) begin
            if (hitQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL unexpected_hit: got seq_hit=1, expected 0 (cycle %0d)", cyc);
            end else begin
                monH = hitQ.pop_front();
                checkOutput("hit_cycle", cyc, monH.cyc);
                checkOutput("hit_cnt", 32'(hit_cnt), 32'(monH.cnt));
                checkOutput("seq_hit_sat", 32'(seq_hit2), 32'd1);
                checkOutput("hit_cnt_sat", 32'(hit_cnt2), 32'(monH.cnt2));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic vld, input logic [7:0] data);
        din_vld = vld;
        din     = data;
        step();
    endtask

    task automatic idle(input int n);
        din_vld = 1'b0;
        repeat (n) step();
    endtask

    task automatic flushChain();
        din_vld = 1'b0;
        flush   = 1'b1;
        step();
        flush   = 1'b0;
    endtask

    task automatic expectWord(input logic [7:0] data, input int atCyc);
        wordQ.push_back('{data: data, cyc: atCyc});
    endtask

    task automatic expectHit(input int atCyc);
        modelCnt++;
        if (modelCnt2 < 3) modelCnt2++;
        hitQ.push_back('{cyc: atCyc, cnt: 16'(modelCnt), cnt2: 2'(modelCnt2)});
    endtask

    task automatic checkDrained(input string tag);
        checkOutput({tag, "_words_left"}, wordQ.size(), 0);
        checkOutput({tag, "_hits_left"}, hitQ.size(), 0);
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int sels[6] = '{0, 1, 2, 3, 4, 7};
        int lats[6] = '{0, 1, 2, 3, 4, 4};

        // Reset with a live bypass word: outputs must still read zero.
        rst = 1'b0; en = 1'b1; flush = 1'b0;
        din_vld = 1'b1; din = 8'h5A; delay_sel = 3'd0;
        pat0 = 8'hEE; pat1 = 8'hEE; pat2 = 8'hEE;
        #1;
        checkOutput("rst_dout", 32'(dout), 32'h0);
        checkOutput("rst_dout_vld", 32'(dout_vld), 32'h0);
        checkOutput("rst_hit_cnt", 32'(hit_cnt), 32'h0);
        din_vld = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        step();

        $display("[TB] latency sweep");
        for (int i = 0; i < 6; i++) begin
            delay_sel = 3'(sels[i]);
            for (int j = 1; j <= 3; j++) begin
                expectWord(8'(j), cyc + lats[i]);
                applyStimulus(1'b1, 8'(j));
            end
            idle(6);
            checkDrained("sweep");
        end

        $display("[TB] stall");
        delay_sel = 3'd3;
        flushChain();
        expectWord(8'hA5, cyc + 5);
        din_vld = 1'b1; din = 8'hA5;
        step();
        din_vld = 1'b0; en = 1'b0;
        step();
        step();
        en = 1'b1;
        idle(6);
        checkDrained("stall");

        $display("[TB] stall with flush");
        flushChain();
        din_vld = 1'b1; din = 8'hA5;
        step();
        din_vld = 1'b0; en = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        en = 1'b1;
        step();
        step();
        @(negedge clk);
        checkOutput("flush_dout_vld", 32'(dout_vld), 32'h0);
        idle(4);
        checkDrained("flush");

        $display("[TB] detection");
        delay_sel = 3'd1;
        pat0 = 8'h01; pat1 = 8'h01; pat2 = 8'h03;
        flushChain();
        baseCyc = cyc;
        expectHit(baseCyc + 5);
        expectWord(8'h01, cyc + 1); applyStimulus(1'b1, 8'h01);
        expectWord(8'h01, cyc + 1); applyStimulus(1'b1, 8'h01);
        expectWord(8'h01, cyc + 1); applyStimulus(1'b1, 8'h01);
        expectWord(8'h03, cyc + 1); applyStimulus(1'b1, 8'h03);
        idle(4);
        checkDrained("detect");

        $display("[TB] overlap");
        pat2 = 8'h01;
        flushChain();
        baseCyc = cyc;
        expectHit(baseCyc + 4);
        expectHit(baseCyc + 5);
        expectHit(baseCyc + 6);
        for (int t = 0; t < 5; t++) begin
            expectWord(8'h01, cyc + 1);
            applyStimulus(1'b1, 8'h01);
        end
        idle(4);
        checkDrained("overlap");

        $display("[TB] overlap with bubbles");
        flushChain();
        baseCyc = cyc;
        expectHit(baseCyc + 6);
        expectHit(baseCyc + 8);
        expectHit(baseCyc + 10);
        for (int t = 0; t < 9; t++) begin
            if (t % 2 == 0) begin
                expectWord(8'h01, cyc + 1);
                applyStimulus(1'b1, 8'h01);
            end else begin
                applyStimulus(1'b0, 8'h00);
            end
        end
        idle(4);
        checkDrained("bubble");

        $display("[TB] mid-stream reset");
        pat0 = 8'hEE; pat1 = 8'hEE; pat2 = 8'hEE;
        delay_sel = 3'd2;
        flushChain();
        expectWord(8'h11, cyc + 2);
        applyStimulus(1'b1, 8'h11);
        applyStimulus(1'b1, 8'h22);
        din_vld = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("midrst_dout", 32'(dout), 32'h0);
        checkOutput("midrst_dout_vld", 32'(dout_vld), 32'h0);
        checkOutput("midrst_hit_cnt", 32'(hit_cnt), 32'h0);
        checkOutput("midrst_hit_cnt_sat", 32'(hit_cnt2), 32'h0);
        modelCnt  = 0;
        modelCnt2 = 0;
        #1 rst = 1'b1;
        step();
        expectWord(8'h33, cyc + 2);
        applyStimulus(1'b1, 8'h33);
        idle(4);
        checkDrained("midrst");

        $display("[TB] saturation");
        delay_sel = 3'd1;
        pat0 = 8'h01; pat1 = 8'h02; pat2 = 8'h03;
        flushChain();
        baseCyc = cyc;
        for (int i = 0; i < 6; i++) expectHit(baseCyc + 3 * i + 4);
        for (int i = 0; i < 6; i++) begin
            for (int w = 1; w <= 3; w++) begin
                expectWord(8'(w), cyc + 1);
                applyStimulus(1'b1, 8'(w));
            end
        end
        idle(4);
        checkDrained("sat");
        checkOutput("final_hit_cnt", 32'(hit_cnt), 32'd6);
        checkOutput("final_hit_cnt_sat", 32'(hit_cnt2), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
